exec_mem_slice: RTL and testbench

Execute/memory/write-back slice of the single-cycle RISC-V datapath: general-purpose register file, 2-bit-opcode ALU with immediate-select operand mux, word data memory, and write-back mux. Fetch, decode, immediate generation and PC logic sit upstream and drive this block's register pointers, immediate and control strobes every cycle.

---
 rtl/exec_mem_slice_pkg.sv | 16 +
 rtl/exec_mem_slice_alu.sv | 27 ++
 rtl/exec_mem_slice_data_mem.sv | 31 +++
 rtl/exec_mem_slice_reg_file.sv | 35 +++
 rtl/exec_mem_slice.sv | 69 ++++++
 tb/tb_exec_mem_slice.sv | 203 ++++++++++++++++++++
 6 files changed

// File: rtl/exec_mem_slice_pkg.sv
// Shared definitions for the execute/memory/write-back slice:
// ALU operation encodings and default widths.
package exec_mem_slice_pkg;

   localparam int BITS_DEF     = 32;
   localparam int N_DEF        = 32;
   localparam int MEM_SIZE_DEF = 64;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_OR  = 2'b11
   } alu_op_e;

endpackage

// File: rtl/exec_mem_slice_alu.sv
// Two-bit-opcode ALU: add, subtract, and, or; wraps modulo 2^Bits.
module alu
   import exec_mem_slice_pkg::*;
#(
   parameter int Bits = BITS_DEF
) (
   input  logic [Bits-1:0] a_i,
   input  logic [Bits-1:0] b_i,
   input  logic [1:0]      op_i,
   output logic [Bits-1:0] result_o,
   output logic            zero_o
);

   always_comb begin
      result_o = '0;
      case (op_i)
         ALU_ADD: result_o = a_i + b_i;
         ALU_SUB: result_o = a_i - b_i;
         ALU_AND: result_o = a_i & b_i;
         ALU_OR:  result_o = a_i | b_i;
         default: result_o = '0;
      endcase
   end

   assign zero_o = (result_o == '0);

endmodule

// File: rtl/exec_mem_slice_data_mem.sv
// Word-addressed data memory with combinational gated read and clocked write.
// Every word clears on async reset.
module data_mem
   import exec_mem_slice_pkg::*;
#(
   parameter int Bits    = BITS_DEF,
   parameter int MemSize = MEM_SIZE_DEF,
   parameter int IdxW    = $clog2(MemSize)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            we_i,
   input  logic            re_i,
   input  logic [IdxW-1:0] idx_i,
   input  logic [Bits-1:0] wdata_i,
   output logic [Bits-1:0] rdata_o
);

   logic [Bits-1:0] mem_q [MemSize];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < MemSize; i++) mem_q[i] <= '0;
      end else if (we_i) begin
         mem_q[idx_i] <= wdata_i;
      end
   end

   assign rdata_o = re_i ? mem_q[idx_i] : '0;

endmodule

// File: rtl/exec_mem_slice_reg_file.sv
// General-purpose register file: two combinational read ports, one write port.
// Register 0 is hard-wired to zero; all registers clear on async reset.
module reg_file
   import exec_mem_slice_pkg::*;
#(
   parameter int Bits = BITS_DEF,
   parameter int N    = N_DEF,
   parameter int PtrW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            we_i,
   input  logic [PtrW-1:0] ptr_rd_1_i,
   input  logic [PtrW-1:0] ptr_rd_2_i,
   input  logic [PtrW-1:0] ptr_wr_i,
   input  logic [Bits-1:0] data_wr_i,
   output logic [Bits-1:0] data_rd_1_o,
   output logic [Bits-1:0] data_rd_2_o
);

   logic [Bits-1:0] regs_q [N];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N; i++) regs_q[i] <= '0;
      end else if (we_i && (ptr_wr_i != '0)) begin
         regs_q[ptr_wr_i] <= data_wr_i;
      end
   end

   // regs_q[0] is never written, but the explicit compare keeps x0 obviously zero
   assign data_rd_1_o = (ptr_rd_1_i == '0) ? '0 : regs_q[ptr_rd_1_i];
   assign data_rd_2_o = (ptr_rd_2_i == '0) ? '0 : regs_q[ptr_rd_2_i];

endmodule

// File: rtl/exec_mem_slice.sv
// Execute/memory/write-back slice: register file, ALU, data memory,
// plus the operand-B and write-back muxes. Fully combinational between edges.
module exec_mem_slice
   import exec_mem_slice_pkg::*;
#(
   parameter int Bits    = BITS_DEF,
   parameter int N       = N_DEF,
   parameter int MemSize = MEM_SIZE_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 reg_write,
   input  logic [$clog2(N)-1:0] ptr_rd_1,
   input  logic [$clog2(N)-1:0] ptr_rd_2,
   input  logic [$clog2(N)-1:0] ptr_wr,
   input  logic [Bits-1:0]      imm,
   input  logic                 alu_src,
   input  logic [1:0]           alu_op,
   input  logic                 mem_write,
   input  logic                 mem_read,
   input  logic                 mem_to_reg,
   output logic [Bits-1:0]      data_rd_1,
   output logic [Bits-1:0]      data_rd_2,
   output logic [Bits-1:0]      alu_result,
   output logic                 zero,
   output logic [Bits-1:0]      mem_read_data,
   output logic [Bits-1:0]      wb_data
);

   localparam int IdxW = $clog2(MemSize);

   logic [Bits-1:0] operand_b;

   reg_file #(.Bits(Bits), .N(N)) u_reg_file (
      .clk         (clk),
      .rst         (rst),
      .we_i        (reg_write),
      .ptr_rd_1_i  (ptr_rd_1),
      .ptr_rd_2_i  (ptr_rd_2),
      .ptr_wr_i    (ptr_wr),
      .data_wr_i   (wb_data),
      .data_rd_1_o (data_rd_1),
      .data_rd_2_o (data_rd_2)
   );

   assign operand_b = alu_src ? imm : data_rd_2;

   alu #(.Bits(Bits)) u_alu (
      .a_i      (data_rd_1),
      .b_i      (operand_b),
      .op_i     (alu_op),
      .result_o (alu_result),
      .zero_o   (zero)
   );

   // Byte address: drop the two offset bits, upper bits wrap the word index
   data_mem #(.Bits(Bits), .MemSize(MemSize)) u_data_mem (
      .clk     (clk),
      .rst     (rst),
      .we_i    (mem_write),
      .re_i    (mem_read),
      .idx_i   (alu_result[IdxW+1:2]),
      .wdata_i (data_rd_2),
      .rdata_o (mem_read_data)
   );

   assign wb_data = mem_to_reg ? mem_read_data : alu_result;

endmodule

// File: tb/tb_exec_mem_slice.sv
// Directed bench for exec_mem_slice: a reference model of registers and memory
// feeds a scoreboard queue that is drained at the falling edge.
module tb_exec_mem_slice;

   logic        clk = 1'b0;
   logic        rst;
   logic        reg_write;
   logic [4:0]  ptr_rd_1, ptr_rd_2, ptr_wr;
   logic [31:0] imm;
   logic        alu_src;
   logic [1:0]  alu_op;
   logic        mem_write, mem_read, mem_to_reg;
   logic [31:0] data_rd_1, data_rd_2, alu_result, mem_read_data, wb_data;
   logic        zero;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string       tag;
      logic [31:0] rd1, rd2, alu;
      logic        z;
      logic [31:0] mrd, wb;
      int          idx;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] m_regs [32];
   logic [31:0] m_mem  [64];

   exec_mem_slice dut (
      .clk           (clk),
      .rst           (rst),
      .reg_write     (reg_write),
      .ptr_rd_1      (ptr_rd_1),
      .ptr_rd_2      (ptr_rd_2),
      .ptr_wr        (ptr_wr),
      .imm           (imm),
      .alu_src       (alu_src),
      .alu_op        (alu_op),
      .mem_write     (mem_write),
      .mem_read      (mem_read),
      .mem_to_reg    (mem_to_reg),
      .data_rd_1     (data_rd_1),
      .data_rd_2     (data_rd_2),
      .alu_result    (alu_result),
      .zero          (zero),
      .mem_read_data (mem_read_data),
      .wb_data       (wb_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      for (int i = 0; i < 64; i++) m_mem[i] = '0;
   endtask

   task automatic idle();
      reg_write = 0; ptr_rd_1 = 0; ptr_rd_2 = 0; ptr_wr = 0; imm = 0;
      alu_src = 0; alu_op = 2'b00; mem_write = 0; mem_read = 0; mem_to_reg = 0;
   endtask

   // Predict outputs from the model, push, then compare at the falling edge.
   task automatic expect_now(input string tag);
      exp_t e, got;
      logic [31:0] b;
      e.tag = tag;
      e.rd1 = (ptr_rd_1 == 0) ? 32'd0 : m_regs[ptr_rd_1];
      e.rd2 = (ptr_rd_2 == 0) ? 32'd0 : m_regs[ptr_rd_2];
      b = alu_src ? imm : e.rd2;
      case (alu_op)
         2'b00:   e.alu = e.rd1 + b;
         2'b01:   e.alu = e.rd1 - b;
         2'b10:   e.alu = e.rd1 & b;
         default: e.alu = e.rd1 | b;
      endcase
      e.z   = (e.alu == 0);
      e.idx = int'(e.alu[7:2]);
      e.mrd = mem_read ? m_mem[e.idx] : 32'd0;
      e.wb  = mem_to_reg ? e.mrd : e.alu;
      sb.push_back(e);
      @(negedge clk);
      got = sb.pop_front();
      chk({got.tag, ".rd1"}, data_rd_1, got.rd1);
      chk({got.tag, ".rd2"}, data_rd_2, got.rd2);
      chk({got.tag, ".alu"}, alu_result, got.alu);
      chk({got.tag, ".zero"}, {31'd0, zero}, {31'd0, got.z});
      chk({got.tag, ".mrd"}, mem_read_data, got.mrd);
      chk({got.tag, ".wb"}, wb_data, got.wb);
      sb.push_back(got);
   endtask

   // Commit the pending transaction into the model across the rising edge.
   task automatic tick();
      exp_t e;
      e = sb.pop_front();
      @(posedge clk);
      if (rst) begin
         if (mem_write) m_mem[e.idx] = e.rd2;
         if (reg_write && ptr_wr != 0) m_regs[ptr_wr] = e.wb;
      end
      #1;
   endtask

   task automatic load_reg(input logic [4:0] r, input logic [31:0] v);
      idle();
      reg_write = 1; ptr_wr = r; alu_src = 1; imm = v;
      expect_now("load_reg");
      tick();
   endtask

   initial begin
      idle();
      rst = 0;
      model_clear();
      #1;
      expect_now("reset_idle");
      chk("reset_zero_flag", {31'd0, zero}, 32'd1);
      tick();
      rst = 1;

      load_reg(5'd1, 32'd7);
      load_reg(5'd2, 32'd5);
      load_reg(5'd5, 32'hFFFF_FFFF);
      load_reg(5'd6, 32'd16);
      load_reg(5'd7, 32'd8);
      load_reg(5'd8, 32'hDEAD_BEEF);
      load_reg(5'd9, 32'd7);
      load_reg(5'd10, 32'd256);

      idle(); ptr_rd_1 = 1; ptr_rd_2 = 2;
      alu_op = 2'b00; expect_now("alu_add"); chk("alu_add_const", alu_result, 32'd12); tick();
      alu_op = 2'b01; expect_now("alu_sub"); chk("alu_sub_const", alu_result, 32'd2);  tick();
      alu_op = 2'b10; expect_now("alu_and"); chk("alu_and_const", alu_result, 32'd5);  tick();
      alu_op = 2'b11; expect_now("alu_or");  chk("alu_or_const",  alu_result, 32'd7);  tick();
      ptr_rd_2 = 9; alu_op = 2'b01;
      expect_now("alu_sub_zero"); chk("alu_sub_zero_flag", {31'd0, zero}, 32'd1); tick();

      idle(); ptr_rd_1 = 5; alu_src = 1; imm = 32'd1;
      expect_now("alu_wrap"); chk("alu_wrap_const", alu_result, 32'd0); tick();

      idle(); ptr_rd_1 = 6; alu_src = 1; imm = 32'hFFFF_FFFC;
      expect_now("imm_neg"); chk("imm_neg_const", alu_result, 32'd12); tick();

      idle(); ptr_rd_1 = 7; ptr_rd_2 = 8; alu_src = 1; imm = 32'd4; mem_write = 1;
      expect_now("store12"); tick();
      idle(); ptr_rd_1 = 7; alu_src = 1; imm = 32'd4;
      mem_read = 1; mem_to_reg = 1; reg_write = 1; ptr_wr = 3;
      expect_now("load12"); chk("load12_const", mem_read_data, 32'hDEAD_BEEF); tick();
      idle(); ptr_rd_1 = 3;
      expect_now("reg3_after_load"); chk("reg3_const", data_rd_1, 32'hDEAD_BEEF); tick();
      idle(); ptr_rd_1 = 7; alu_src = 1; imm = 32'd5; mem_read = 1;
      expect_now("load13"); chk("load13_const", mem_read_data, 32'hDEAD_BEEF); tick();

      idle(); ptr_rd_1 = 7; ptr_rd_2 = 1; alu_src = 1; imm = 32'd4; mem_write = 1; mem_read = 1;
      expect_now("rw_same_cycle"); chk("rw_old_const", mem_read_data, 32'hDEAD_BEEF); tick();
      mem_write = 0;
      expect_now("rw_next_cycle"); chk("rw_new_const", mem_read_data, 32'd7); tick();

      idle(); reg_write = 1; ptr_wr = 0; alu_src = 1; imm = 32'd55;
      expect_now("x0_write"); tick();
      idle();
      expect_now("x0_read"); chk("x0_const", data_rd_1, 32'd0); tick();

      idle(); reg_write = 1; ptr_wr = 4; alu_src = 1; imm = 32'd9; ptr_rd_1 = 4;
      expect_now("hazard_same"); chk("hazard_old_const", data_rd_1, 32'd0); tick();
      idle(); ptr_rd_1 = 4;
      expect_now("hazard_next"); chk("hazard_new_const", data_rd_1, 32'd9); tick();

      idle(); ptr_rd_1 = 10; ptr_rd_2 = 1; mem_write = 1; alu_src = 1; imm = 32'd0;
      expect_now("store256"); tick();
      idle(); mem_read = 1;
      expect_now("load0_wrap"); chk("wrap_const", mem_read_data, 32'd7); tick();
      idle(); mem_read = 0;
      expect_now("read_gated"); chk("read_gated_const", mem_read_data, 32'd0); tick();

      idle(); reg_write = 1; ptr_wr = 1; alu_src = 1; imm = 32'd99; ptr_rd_1 = 1;
      rst = 0;
      #1;
      model_clear();
      chk("rst_async_rd1", data_rd_1, 32'd0);
      expect_now("reset_mid");
      tick();
      rst = 1;
      idle(); ptr_rd_1 = 1; ptr_rd_2 = 8;
      expect_now("post_reset_regs"); chk("post_reset_reg1", data_rd_1, 32'd0); tick();
      idle(); ptr_rd_1 = 7; alu_src = 1; imm = 32'd4; mem_read = 1;
      expect_now("post_reset_mem"); chk("post_reset_mem_const", mem_read_data, 32'd0); tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
